tdiv_bank: RTL
==============

TDIV_BANK -- requirements
Module: tdiv_bank

Interface
REQ-001 Parameter NCH, default 4, number of independent trigger channels (1..16).
REQ-002 Parameter W, default 8, divisor register width in bits (2..16).
REQ-003 Parameter DIV_INIT, default 0, reset value of every channel divisor.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset; asynchronous assert, active-low.
REQ-006 EN  input  NCH  per-channel enable; 0 freezes the channel.
REQ-007 MODE  input  NCH  per-channel mode: 0 = T-trigger, 1 = divider.
REQ-008 T  input  NCH  per-channel toggle request, used in T-trigger mode only.
REQ-009 DIV_WR  input  1  one-cycle divisor write strobe.
REQ-010 DIV_SEL  input  $clog2(NCH) (min 1)  channel index for the write.
REQ-011 DIV_DATA  input  W  divisor value to write.
REQ-012 Q  output  NCH  registered trigger outputs.
REQ-013 TICK  output  NCH  registered one-cycle pulse, high in the same cycle a Q bit changes.

Function
REQ-014 T-trigger mode: the edge with EN=1 and T=1 inverts Q; otherwise Q holds; the channel counter is held at 0.
REQ-015 Divider mode: a W-bit counter increments on each edge with EN=1; at count==DIV the counter wraps to 0 and Q inverts on that edge.
REQ-016 Divider output period SHALL be 2*(DIV+1) CLK cycles; DIV=0 gives CLK/2, DIV=2^W-1 gives CLK/2^(W+1).
REQ-017 EN=0 holds counter and Q in both modes; TICK is 0.
REQ-018 TICK[i] is 1 for exactly the cycle following each edge on which Q[i] inverted; never asserted otherwise.
REQ-019 DIV_WR=1 with DIV_SEL<NCH loads DIV_DATA into that channel's divisor and clears its counter on the same edge; Q unchanged.
REQ-020 DIV_WR with DIV_SEL>=NCH is ignored; no state changes.
REQ-021 A write coinciding with a terminal count on the same channel: the write wins; no Q toggle, no TICK, counter = 0.
REQ-022 A change of MODE[i] (sampled versus previous cycle) clears counter i on that edge; Q[i] holds and does not toggle that edge.
REQ-023 Writes to one channel do not disturb the counter, Q or TICK of any other channel.
REQ-024 Counter compare is unsigned; a newly written DIV below the current count cannot occur, since the write clears the counter.
REQ-025 Outputs SHALL be glitch-free flop outputs; no combinational path from inputs to Q or TICK.

Reset
REQ-026 RST_N=0 asynchronously forces Q=0, TICK=0, all counters=0, all divisors=DIV_INIT, and stored previous MODE=0.
REQ-027 Reset asserted mid-count aborts the count; after release the first toggle in divider mode occurs DIV_INIT+1 enabled edges later.
REQ-028 Release of RST_N is synchronous to CLK; the first edge after release is a normal functional edge.

Structure
REQ-029 Shared package tdiv_pkg holds the mode encoding constants (MODE_T=0, MODE_DIV=1) and the NCH/W limit constants.
REQ-030 One sub-module tdiv_chan implements a single channel (counter, divisor register, Q, TICK, mode tracking); tdiv_bank instantiates NCH copies and decodes DIV_WR/DIV_SEL into per-channel write strobes.

Verification
REQ-031 Reset: hold RST_N=0 for 3 cycles with T=all 1 and EN=all 1 -> Q=0, TICK=0 throughout; release, first edge in T mode -> Q=all 1.
REQ-032 T mode, ch0: EN=1, T pulsed high on 5 edges -> Q[0] toggles 5 times, ends at 1, 5 TICK pulses; other channels static.
REQ-033 Divider: write DIV=3 to ch1, MODE[1]=1, EN[1]=1 -> Q[1] period 8 cycles, 50% duty; TICK[1] every 4 cycles.
REQ-034 Boundary: DIV=0 gives Q toggling every cycle; DIV=255 (W=8) gives a 512-cycle period; EN dropped for 10 cycles mid-count stretches exactly one half-period by 10.
REQ-035 Collision: write DIV=5 to ch2 on its terminal-count edge -> no toggle, next toggle 6 enabled edges later; write with DIV_SEL=NCH -> no change on any channel.
REQ-036 Async reset mid-count: assert RST_N between edges during a DIV=7 count -> Q, TICK and counter clear immediately without waiting for CLK; divisor returns to DIV_INIT.

Source files
------------

// File: rtl/tdiv_pkg.sv
// Shared definitions for the trigger/divider bank.
//   mode_e      : per-channel mode encoding (T-trigger / divider)
//   *_MIN/_MAX  : legal ranges for the channel count and divisor width
//   sel_width() : width of the channel-select field, never below 1 bit
package tdiv_pkg;

  typedef enum logic {
    MODE_T   = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  localparam int NCH_MIN = 1;
  localparam int NCH_MAX = 16;
  localparam int W_MIN   = 2;
  localparam int W_MAX   = 16;

  function automatic int sel_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tdiv_bank_if.sv
// Control/status bundle for tdiv_bank.
//   en, mode, t      : per-channel enable, mode select, toggle request
//   div_wr, div_sel,
//   div_data         : divisor write strobe, channel index, value
//   q, tick          : per-channel registered output and change pulse
// master = controller side, slave = tdiv_bank side.
interface tdiv_bank_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  import tdiv_pkg::*;

  localparam int SW = sel_width(NCH);

  logic [NCH-1:0] en;
  logic [NCH-1:0] mode;
  logic [NCH-1:0] t;
  logic           div_wr;
  logic [SW-1:0]  div_sel;
  logic [W-1:0]   div_data;
  logic [NCH-1:0] q;
  logic [NCH-1:0] tick;

  modport master (
    output en, mode, t, div_wr, div_sel, div_data,
    input  q, tick
  );

  modport slave (
    input  en, mode, t, div_wr, div_sel, div_data,
    output q, tick
  );

endinterface

// File: rtl/tdiv_chan.sv
// One trigger channel: T flip-flop or programmable divide-by-2*(div+1).
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : 0 freezes counter and q
//   mode       : 0 = T-trigger, 1 = divider
//   t          : toggle request (T-trigger mode)
//   wr         : load wr_data into the divisor and restart the count
//   q, tick    : registered output and one-cycle pulse when q changed
module tdiv_chan
  import tdiv_pkg::*;
#(
  parameter int             W        = 8,
  parameter logic [W-1:0]   DIV_INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic         t,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  output logic         q,
  output logic         tick
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] div_reg;
  logic         q_reg;
  logic         tick_reg;
  logic         mode_prev_reg;

  // Priority: divisor write, then mode change, then normal counting.
  // Both restart events clear the counter and suppress any toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      div_reg       <= DIV_INIT;
      q_reg         <= 1'b0;
      tick_reg      <= 1'b0;
      mode_prev_reg <= MODE_T;
    end else begin
      mode_prev_reg <= mode;
      tick_reg      <= 1'b0;
      if (wr) begin
        div_reg <= wr_data;
        cnt_reg <= '0;
      end else if (mode != mode_prev_reg) begin
        cnt_reg <= '0;
      end else if (en) begin
        if (mode == MODE_T) begin
          cnt_reg <= '0;
          if (t) begin
            q_reg    <= ~q_reg;
            tick_reg <= 1'b1;
          end
        end else if (cnt_reg == div_reg) begin
          cnt_reg  <= '0;
          q_reg    <= ~q_reg;
          tick_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + W'(1);
        end
      end
    end
  end

  assign q    = q_reg;
  assign tick = tick_reg;

endmodule

// File: rtl/tdiv_bank.sv
// Bank of NCH independent T-trigger / clock-divider channels.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tdiv_bank_if slave (controls in, q/tick out)
// A divisor write addresses one channel; an out-of-range div_sel
// matches no channel and is silently dropped.
module tdiv_bank
  import tdiv_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = 8,
  parameter int DIV_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  tdiv_bank_if.slave  bus
);

  localparam int SW = sel_width(NCH);

  logic [NCH-1:0] wr_w;
  logic [NCH-1:0] q_w;
  logic [NCH-1:0] tick_w;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign wr_w[gi] = bus.div_wr && (bus.div_sel == SW'(gi));

      tdiv_chan #(
        .W        (W),
        .DIV_INIT (W'(DIV_INIT))
      ) u_chan (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus.en[gi]),
        .mode    (bus.mode[gi]),
        .t       (bus.t[gi]),
        .wr      (wr_w[gi]),
        .wr_data (bus.div_data),
        .q       (q_w[gi]),
        .tick    (tick_w[gi])
      );
    end
  endgenerate

  assign bus.q    = q_w;
  assign bus.tick = tick_w;

endmodule
